// File: rtl/mul_tree_pipe.sv
// Three-stage 64x64 multiplier: operand capture, radix-4 Booth rows reduced to four
// carry-save rows, then final 4:2 compression and carry-propagate add.
module mul_tree_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        mul_valid,
  output logic        mul_ready,
  input  logic [1:0]  mul_signed,
  input  logic        mulw,
  input  logic [63:0] multiplicand,
  input  logic [63:0] multiplier,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result_hi,
  output logic [63:0] result_lo
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned OPW  = 65;
  localparam int unsigned PPW  = 132;
  localparam int unsigned PW   = 128;
  localparam int unsigned ROWS = 33;
  localparam int unsigned HALF = 17;

  // Booth digit select: sel = {b[2i+1], b[2i], b[2i-1]}
  function automatic logic [PPW-1:0] booth_pp(input logic [OPW-1:0] x, input logic [2:0] sel);
    logic [PPW-1:0] xs;
    xs = {{(PPW-OPW){x[OPW-1]}}, x};
    case (sel)
      3'b001, 3'b010: booth_pp = xs;
      3'b011:         booth_pp = xs << 1;
      3'b100:         booth_pp = -(xs << 1);
      3'b101, 3'b110: booth_pp = -xs;
      default:        booth_pp = '0;
    endcase
  endfunction

  function automatic logic [2*PPW-1:0] csa(input logic [PPW-1:0] x, input logic [PPW-1:0] y,
                                           input logic [PPW-1:0] z);
    csa = {x ^ y ^ z, ((x & y) | (x & z) | (y & z)) << 1};
  endfunction

  logic stall;
  logic accept;

  assign stall     = out_valid & ~out_ready;
  assign mul_ready = ~stall;
  assign accept    = mul_valid & mul_ready & ~flush;

  logic                      s1_valid;
  logic                      s1_mulw;
  logic [OPW-1:0]            s1_a;
  logic [OPW-1:0]            s1_b;
  logic                      s2_valid;
  logic                      s2_mulw;
  logic [3:0][PPW-1:0]       s2_row;

  // Stage 2 combinational: Booth rows, two CSA chains of 17 and 16 rows
  logic [OPW+1:0] b_ext;
  logic [PPW-1:0] pp [ROWS];
  logic [PPW-1:0] sa, ca, sb, cb;

  always_comb begin
    b_ext = {s1_b[OPW-1], s1_b, 1'b0};
    for (int i = 0; i < ROWS; i++) begin
      pp[i] = booth_pp(s1_a, b_ext[2*i +: 3]) << (2*i);
    end
    sa = pp[0];
    ca = pp[1];
    for (int i = 2; i < HALF; i++) begin
      {sa, ca} = csa(sa, ca, pp[i]);
    end
    sb = pp[HALF];
    cb = pp[HALF+1];
    for (int i = HALF + 2; i < ROWS; i++) begin
      {sb, cb} = csa(sb, cb, pp[i]);
    end
  end

  // Stage 3 combinational: 4 -> 2 compression and final add
  logic [PPW-1:0]  r_s, r_c, f_s, f_c, sum;
  logic [XLEN-1:0] hi_n, lo_n;
  logic [3:0]      unused_sum_top;

  always_comb begin
    {r_s, r_c} = csa(s2_row[0], s2_row[1], s2_row[2]);
    {f_s, f_c} = csa(r_s, r_c, s2_row[3]);
    sum        = f_s + f_c;
    lo_n       = s2_mulw ? {{32{sum[31]}}, sum[31:0]} : sum[XLEN-1:0];
    hi_n       = s2_mulw ? '0 : sum[PW-1:XLEN];
  end

  assign unused_sum_top = sum[PPW-1:PW];

  // Valid pipeline; flush wins over stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid  <= accept;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_mulw   <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_mulw   <= 1'b0;
      s2_row    <= '0;
      result_hi <= '0;
      result_lo <= '0;
    end else begin
      if (accept) begin
        s1_mulw <= mulw;
        s1_a    <= {mul_signed[1] & multiplicand[XLEN-1], multiplicand};
        s1_b    <= {mul_signed[0] & multiplier[XLEN-1], multiplier};
      end
      if (!stall && s1_valid) begin
        s2_mulw <= s1_mulw;
        s2_row  <= {cb, sb, ca, sa};
      end
      if (!stall && s2_valid) begin
        result_hi <= hi_n;
        result_lo <= lo_n;
      end
    end
  end

endmodule

// File: tb/tb_mul_tree_pipe.sv
// Directed and randomized checks of mul_tree_pipe against hand values and a
// plain 128-bit product model, with an in-order scoreboard.
module tb_mul_tree_pipe;

  logic        clk;
  logic        rst;
  logic        mul_valid;
  logic        mul_ready;
  logic [1:0]  mul_signed;
  logic        mulw;
  logic [63:0] multiplicand;
  logic [63:0] multiplier;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result_hi;
  logic [63:0] result_lo;

  mul_tree_pipe dut (
    .clk(clk), .rst(rst), .mul_valid(mul_valid), .mul_ready(mul_ready),
    .mul_signed(mul_signed), .mulw(mulw), .multiplicand(multiplicand),
    .multiplier(multiplier), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result_hi(result_hi), .result_lo(result_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;

  logic [127:0] q[$];
  logic [127:0] exp_next;
  logic [127:0] e;
  bit           accepted, was_stall, rand_rdy;
  logic [63:0]  prev_hi, prev_lo;

  localparam int NV = 11;
  logic [63:0]  va [NV];
  logic [63:0]  vb [NV];
  logic [1:0]   vs [NV];
  logic         vw [NV];
  logic [127:0] ve [NV];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] sg, input logic w);
    logic [127:0] ax, bx, p;
    ax = sg[1] ? {{64{a[63]}}, a} : {64'd0, a};
    bx = sg[0] ? {{64{b[63]}}, b} : {64'd0, b};
    p  = ax * bx;
    if (w) ref_mul = {64'd0, {32{p[31]}}, p[31:0]};
    else   ref_mul = p;
  endfunction

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       rnd_op = 64'd0;
      1:       rnd_op = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       rnd_op = 64'h8000_0000_0000_0000;
      3:       rnd_op = {32'd0, 32'($urandom())};
      default: rnd_op = {32'($urandom()), 32'($urandom())};
    endcase
  endfunction

  // One cycle: evaluate handshakes at the current inputs, then advance past the edge
  task automatic tick();
    bit acc;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    #1;
    if (was_stall) begin
      chk("stall_valid", 128'(out_valid), 128'(1));
      chk("stall_hi", 128'(result_hi), 128'(prev_hi));
      chk("stall_lo", 128'(result_lo), 128'(prev_lo));
    end
    chk("ready", 128'(mul_ready), 128'(!(out_valid && !out_ready)));
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 128'(out_valid), 128'(0));
      else begin
        e = q.pop_front();
        chk("res_hi", 128'(result_hi), 128'(e[127:64]));
        chk("res_lo", 128'(result_lo), 128'(e[63:0]));
      end
    end
    acc = mul_valid && mul_ready && !flush;
    if (flush) q.delete();
    else if (acc) q.push_back(exp_next);
    accepted  = acc;
    was_stall = out_valid && !out_ready && !flush;
    prev_hi   = result_hi;
    prev_lo   = result_lo;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sg,
                      input logic w, input logic [127:0] exp);
    multiplicand = a;
    multiplier   = b;
    mul_signed   = sg;
    mulw         = w;
    exp_next     = exp;
    mul_valid    = 1'b1;
    accepted     = 1'b0;
    for (int t = 0; t < 200 && !accepted; t++) tick();
    if (!accepted) chk("accept_timeout", 128'(accepted), 128'(1));
    mul_valid = 1'b0;
    multiplicand = ~a;
    multiplier   = ~b;
  endtask

  task automatic send_v(input int i);
    send(va[i], vb[i], vs[i], vw[i], ve[i]);
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && q.size() != 0; t++) tick();
    chk("drained", 128'(q.size()), 128'(0));
  endtask

  initial begin
    va = '{64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h7FFF_FFFF, 64'd2, 64'h8000_0000_0000_0000, 64'h1_0000_0000,
           64'hDEAD_BEEF_0000_0003, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000};
    vb = '{64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
           64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h1_0000_0000,
           64'h1234_5678_0000_0005, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    vs = '{2'b00, 2'b11, 2'b00, 2'b10, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11};
    vw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ve = '{{64'd0, 64'd15},
           {64'd0, 64'd1},
           {64'hFFFF_FFFF_FFFF_FFFE, 64'd1},
           {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE},
           {64'd0, 64'hFFFF_FFFF_FFFF_FFFE},
           {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE},
           {64'h4000_0000_0000_0000, 64'd0},
           {64'd1, 64'd0},
           {64'd0, 64'd15},
           {64'd0, 64'h8000_0000_0000_0000},
           {64'd0, 64'hFFFF_FFFF_8000_0000}};

    rst = 1'b1; mul_valid = 1'b0; mul_signed = 2'b00; mulw = 1'b0;
    multiplicand = '0; multiplier = '0; flush = 1'b0; out_ready = 1'b1;
    exp_next = '0; was_stall = 1'b0; rand_rdy = 1'b0; accepted = 1'b0;
    prev_hi = '0; prev_lo = '0;

    // Reset state
    #3;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_hi", 128'(result_hi), 128'(0));
    chk("rst_lo", 128'(result_lo), 128'(0));
    chk("rst_ready", 128'(mul_ready), 128'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_ready", 128'(mul_ready), 128'(1));

    // Latency: 3x5 visible after the third edge
    send_v(0);
    chk("lat_e1", 128'(out_valid), 128'(0));
    tick();
    chk("lat_e2", 128'(out_valid), 128'(0));
    tick();
    chk("lat_e3", 128'(out_valid), 128'(1));
    chk("lat_hi", 128'(result_hi), 128'(0));
    chk("lat_lo", 128'(result_lo), 128'(15));
    tick();

    // Back-to-back directed vectors
    for (int i = 1; i < NV; i++) send_v(i);
    drain();

    // Stall: four requests, consumer blocked for 5 cycles after first result
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_v(i);
    chk("stall_ov", 128'(out_valid), 128'(1));
    multiplicand = va[3]; multiplier = vb[3]; mul_signed = vs[3]; mulw = vw[3];
    exp_next = ve[3]; mul_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("stall_ready_low", 128'(mul_ready), 128'(0));
      tick();
    end
    out_ready = 1'b1;
    accepted = 1'b0;
    for (int t = 0; t < 20 && !accepted; t++) tick();
    chk("stall_4th_accepted", 128'(accepted), 128'(1));
    mul_valid = 1'b0;
    drain();

    // Flush with three in flight and a concurrent request
    for (int i = 4; i < 7; i++) send_v(i);
    multiplicand = va[7]; multiplier = vb[7]; mul_signed = vs[7]; mulw = vw[7];
    exp_next = ve[7]; mul_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; mul_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("flush_no_out", 128'(out_valid), 128'(0));
      tick();
    end

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send_v(2);
    for (int t = 0; t < 10 && !out_valid; t++) tick();
    chk("pre_rst_ov", 128'(out_valid), 128'(1));
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ov", 128'(out_valid), 128'(0));
    chk("arst_hi", 128'(result_hi), 128'(0));
    chk("arst_lo", 128'(result_lo), 128'(0));
    chk("arst_ready", 128'(mul_ready), 128'(1));
    q.delete();
    was_stall = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("post_arst_no_out", 128'(out_valid), 128'(0));
      tick();
    end

    // Randomized operands against the product model, random consumer backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      logic [63:0] a, b;
      logic [1:0]  sg;
      logic        w;
      a  = rnd_op();
      b  = rnd_op();
      sg = 2'($urandom_range(0, 3));
      w  = ($urandom_range(0, 3) == 0);
      send(a, b, sg, w, ref_mul(a, b, sg, w));
      if ($urandom_range(0, 7) == 0) tick();
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_tree_pipe.md
MUL_TREE_PIPE -- requirements
Module: mul_tree_pipe

Interface
REQ-001 SHALL have no parameters; operand width fixed at 64, extended operand width 65, partial-product width 132, row count 33.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 mul_valid  input  1  request present on operand inputs.
REQ-005 mul_ready  output  1  block accepts request this cycle.
REQ-006 mul_signed  input  2  bit1 = multiplicand signed, bit0 = multiplier signed.
REQ-007 mulw  input  1  RV64 word multiply (32-bit result, sign-extended).
REQ-008 multiplicand  input  64  operand rs1.
REQ-009 multiplier  input  64  operand rs2.
REQ-010 flush  input  1  discard all in-flight requests.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer takes result this cycle.
REQ-013 result_hi  output  64  product bits [127:64]; 0 when mulw.
REQ-014 result_lo  output  64  product bits [63:0], or sext(product[31:0]) when mulw.

Function
REQ-015 Accept = mul_valid & mul_ready & !flush; mul_ready = !(out_valid & !out_ready) (global stall enable).
REQ-016 Stage S1 (on accept): register 65-bit operands {mul_signed[1]&multiplicand[63], multiplicand} and {mul_signed[0]&multiplier[63], multiplier}, plus mulw flag and valid bit.
REQ-017 Stage S2: feed S1 operands to the existing radix-4 Booth partial-product generator (33 rows x 132 bits, pre-shifted by 2i), reduce 33 rows to 4 rows with 3:2 carry-save adders, register the 4 rows plus valid and mulw.
REQ-018 Stage S3: reduce 4 rows to 2 with CSA, add the two rows with a 132-bit adder, keep sum[127:0], register result_hi/result_lo per REQ-013/014, and set out_valid.
REQ-019 All CSA/adder arithmetic SHALL be modulo 2^132; bits above 127 are discarded.
REQ-020 Latency: request accepted at edge N -> out_valid high after edge N+3, absent stall.
REQ-021 Throughput: one request per cycle; up to 3 requests in flight.
REQ-022 Stall (out_valid & !out_ready): S1, S2, S3 registers SHALL all hold; result_hi/lo and out_valid stable.
REQ-023 An unaccepted cycle SHALL insert a bubble (valid 0) into S1 when not stalled.
REQ-024 flush SHALL clear S1/S2/S3 valid bits at the next edge, override stall, and block acceptance that cycle; result data registers need not clear.
REQ-025 mul_signed = 2'b01 SHALL be legal (unsigned x signed).
REQ-026 Operand inputs SHALL be sampled only on accept; changes while not accepted have no effect.

Reset
REQ-027 On rst assertion, asynchronously: all valid bits 0, out_valid 0, result_hi 0, result_lo 0, all pipeline data registers 0.
REQ-028 mul_ready SHALL read 1 during and immediately after reset.
REQ-029 rst asserted mid-operation SHALL discard all in-flight requests; no out_valid after release until a new accept.

Verification
REQ-030 Unsigned 3 x 5, mul_signed=00, out_ready=1 -> out_valid 3 cycles later, hi=0, lo=15.
REQ-031 Signed 0xFFFF_FFFF_FFFF_FFFF x 0xFFFF_FFFF_FFFF_FFFF, mul_signed=11 -> hi=0, lo=1; same operands mul_signed=00 -> hi=0xFFFF_FFFF_FFFF_FFFE, lo=1.
REQ-032 mul_signed=10, rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=2 -> hi=0xFFFF_FFFF_FFFF_FFFF, lo=0xFFFF_FFFF_FFFF_FFFE; mulw=1, mul_signed=11, rs1=0x7FFF_FFFF, rs2=2 -> hi=0, lo=0xFFFF_FFFF_FFFF_FFFE.
REQ-033 Back-to-back 4 requests with out_ready=0 for 5 cycles after first out_valid -> mul_ready=0 during stall, results emitted in order, none lost or duplicated.
REQ-034 Flush with 3 in flight, concurrent mul_valid=1 -> that request not accepted, no out_valid for following 3 cycles; rst pulse mid-stream -> outputs 0 asynchronously, no stale results afterward.
REQ-035 Random signed/unsigned/mulw operands (>=10k) with random out_ready -> every result matches reference model product.
